// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the rv32i hazard controller: register index and FSM state.
// Imported by the top and the hazard_detect sub-module.
package pipeline_hazard_ctrl_pkg;

   typedef logic [4:0] rv32i_reg;

   localparam rv32i_reg REG_X0 = 5'd0;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      LU_BUBBLE = 2'd1,
      REDIRECT  = 2'd2
   } hazard_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard detection from the ID source fields and the EX destination.
// Purely combinational; x0 never creates a dependency.
module pipeline_hazard_ctrl_hazard_detect
   import pipeline_hazard_ctrl_pkg::*;
(
   input  rv32i_reg id_rs1,
   input  rv32i_reg id_rs2,
   input  logic     id_use_rs1,
   input  logic     id_use_rs2,
   input  rv32i_reg ex_rd,
   input  logic     ex_mem_read,
   output logic     lu_hazard
);

   logic rs1_hit;
   logic rs2_hit;

   assign rs1_hit = id_use_rs1 & (id_rs1 == ex_rd);
   assign rs2_hit = id_use_rs2 & (id_rs2 == ex_rd);

   assign lu_hazard = ex_mem_read & (ex_rd != REG_X0)
                    & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage rv32i pipeline.
// Define HAZARD_PERF_EN to build the stall/bubble/redirect perf counters.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_redirect,
   input  logic             icache_resp,
   input  logic             mem_dreq,
   input  logic             dcache_resp,
   output logic             pc_load,
   output logic             if_id_load,
   output logic             id_ex_load,
   output logic             ex_mem_load,
   output logic             mem_wb_load,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic             mem_wb_flush,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic [CNT_W-1:0] redirect_cnt
);

   hazard_state_t state_q;
   hazard_state_t state_d;

   logic lu_hazard;
   logic freeze;
   logic pc_ld;
   logic if_id_ld;
   logic id_ex_ld;
   logic ex_mem_ld;
   logic mem_wb_ld;
   logic if_id_fl_d;
   logic id_ex_fl_d;

   pipeline_hazard_ctrl_hazard_detect u_hazard_detect (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_use_rs1  (id_use_rs1),
      .id_use_rs2  (id_use_rs2),
      .ex_rd       (ex_rd),
      .ex_mem_read (ex_mem_read),
      .lu_hazard   (lu_hazard)
   );

   assign freeze = ~icache_resp | (mem_dreq & ~dcache_resp);

   always_comb begin
      state_d    = state_q;
      pc_ld      = 1'b0;
      if_id_ld   = 1'b0;
      id_ex_ld   = 1'b0;
      ex_mem_ld  = 1'b0;
      mem_wb_ld  = 1'b0;
      if_id_fl_d = 1'b0;
      id_ex_fl_d = 1'b0;
      if (!freeze) begin
         unique case (state_q)
            RUN: begin
               ex_mem_ld = 1'b1;
               mem_wb_ld = 1'b1;
               if (ex_redirect) begin
                  pc_ld      = 1'b1;
                  if_id_fl_d = 1'b1;
                  id_ex_fl_d = 1'b1;
                  state_d    = REDIRECT;
               end else if (lu_hazard) begin
                  id_ex_fl_d = 1'b1;
                  state_d    = LU_BUBBLE;
               end else begin
                  pc_ld    = 1'b1;
                  if_id_ld = 1'b1;
                  id_ex_ld = 1'b1;
               end
            end
            LU_BUBBLE, REDIRECT: begin
               ex_mem_ld = 1'b1;
               mem_wb_ld = 1'b1;
               state_d   = RUN;
            end
            default: state_d = RUN;
         endcase
      end
   end

   // A stage being cleared this cycle must not also capture new data.
   assign pc_load     = pc_ld & ~rst;
   assign if_id_load  = if_id_ld & ~rst & ~if_id_flush;
   assign id_ex_load  = id_ex_ld & ~rst & ~id_ex_flush;
   assign ex_mem_load = ex_mem_ld & ~rst & ~ex_mem_flush;
   assign mem_wb_load = mem_wb_ld & ~rst & ~mem_wb_flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RUN;
         if_id_flush  <= 1'b1;
         id_ex_flush  <= 1'b1;
         ex_mem_flush <= 1'b1;
         mem_wb_flush <= 1'b1;
      end else begin
         state_q      <= state_d;
         if_id_flush  <= if_id_fl_d;
         id_ex_flush  <= id_ex_fl_d;
         ex_mem_flush <= 1'b0;
         mem_wb_flush <= 1'b0;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] bubble_q;
   logic [CNT_W-1:0] redir_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q  <= '0;
         bubble_q <= '0;
         redir_q  <= '0;
      end else begin
         if (freeze)
            stall_q <= stall_q + CNT_W'(1);
         if (state_q == RUN && state_d == LU_BUBBLE)
            bubble_q <= bubble_q + CNT_W'(1);
         if (state_q == RUN && state_d == REDIRECT)
            redir_q <= redir_q + CNT_W'(1);
      end
   end

   assign stall_cycles = stall_q;
   assign bubble_cnt   = bubble_q;
   assign redirect_cnt = redir_q;
`else
   assign stall_cycles = '0;
   assign bubble_cnt   = '0;
   assign redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: per-cycle expected loads/flushes
// are queued at drive time and compared on the falling edge.
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_use_rs1, id_use_rs2;
   logic        ex_mem_read, ex_redirect;
   logic        icache_resp, mem_dreq, dcache_resp;
   logic        pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
   logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
   logic [31:0] stall_cycles, bubble_cnt, redirect_cnt;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string      tag;
      logic [4:0] ld;
      logic [3:0] fl;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.CNT_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_use_rs1   (id_use_rs1),
      .id_use_rs2   (id_use_rs2),
      .ex_rd        (ex_rd),
      .ex_mem_read  (ex_mem_read),
      .ex_redirect  (ex_redirect),
      .icache_resp  (icache_resp),
      .mem_dreq     (mem_dreq),
      .dcache_resp  (dcache_resp),
      .pc_load      (pc_load),
      .if_id_load   (if_id_load),
      .id_ex_load   (id_ex_load),
      .ex_mem_load  (ex_mem_load),
      .mem_wb_load  (mem_wb_load),
      .if_id_flush  (if_id_flush),
      .id_ex_flush  (id_ex_flush),
      .ex_mem_flush (ex_mem_flush),
      .mem_wb_flush (mem_wb_flush),
      .stall_cycles (stall_cycles),
      .bubble_cnt   (bubble_cnt),
      .redirect_cnt (redirect_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Monitor: pops one expectation per cycle, mid-cycle.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk({e.tag, ".ld"},
             {27'd0, pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load},
             {27'd0, e.ld});
         chk({e.tag, ".fl"},
             {28'd0, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush},
             {28'd0, e.fl});
      end
   end

   task automatic cyc(input string tag, input logic [4:0] ld,
                      input logic [3:0] fl);
      exp_t e;
      e.tag = tag;
      e.ld  = ld;
      e.fl  = fl;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs1      = 5'd0;
      id_rs2      = 5'd0;
      id_use_rs1  = 1'b0;
      id_use_rs2  = 1'b0;
      ex_rd       = 5'd0;
      ex_mem_read = 1'b0;
      ex_redirect = 1'b0;
      icache_resp = 1'b1;
      mem_dreq    = 1'b0;
      dcache_resp = 1'b0;
   endtask

   task automatic cnt_chk(input string tag, input int s, input int b,
                          input int r);
      chk({tag, ".stall"}, stall_cycles, PERF ? s : 0);
      chk({tag, ".bubble"}, bubble_cnt, PERF ? b : 0);
      chk({tag, ".redir"}, redirect_cnt, PERF ? r : 0);
   endtask

   initial begin
      idle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      // reset held, then released: one cycle of full flush
      cyc("rst_a", 5'b00000, 4'b1111);
      cyc("rst_b", 5'b00000, 4'b1111);
      rst = 1'b0;
      cyc("rel", 5'b10000, 4'b1111);
      cyc("run", 5'b11111, 4'b0000);
      cnt_chk("after_rst", 0, 0, 0);

      // load-use through rs2
      ex_mem_read = 1'b1;
      ex_rd       = 5'd5;
      id_rs2      = 5'd5;
      id_use_rs2  = 1'b1;
      cyc("lu2_a", 5'b00011, 4'b0000);
      cyc("lu2_b", 5'b00011, 4'b0100);
      idle();
      cyc("lu2_c", 5'b11111, 4'b0000);
      cnt_chk("lu2", 0, 1, 0);

      // x0 destination and unused rs2: no hazard
      ex_mem_read = 1'b1;
      ex_rd       = 5'd0;
      id_rs2      = 5'd0;
      id_use_rs2  = 1'b1;
      cyc("rd_x0", 5'b11111, 4'b0000);
      ex_rd       = 5'd5;
      id_rs2      = 5'd5;
      id_use_rs2  = 1'b0;
      cyc("no_use", 5'b11111, 4'b0000);

      // load-use through rs1
      idle();
      ex_mem_read = 1'b1;
      ex_rd       = 5'd7;
      id_rs1      = 5'd7;
      id_use_rs1  = 1'b1;
      cyc("lu1_a", 5'b00011, 4'b0000);
      cyc("lu1_b", 5'b00011, 4'b0100);
      idle();
      cyc("lu1_c", 5'b11111, 4'b0000);
      cnt_chk("lu1", 0, 2, 0);

      // redirect
      ex_redirect = 1'b1;
      cyc("rdr_a", 5'b10011, 4'b0000);
      idle();
      cyc("rdr_b", 5'b00011, 4'b1100);
      cyc("rdr_c", 5'b11111, 4'b0000);
      cnt_chk("rdr", 0, 2, 1);

      // D-cache wait over a pending redirect
      ex_redirect = 1'b1;
      mem_dreq    = 1'b1;
      dcache_resp = 1'b0;
      for (int i = 0; i < 4; i++)
         cyc($sformatf("dwait%0d", i), 5'b00000, 4'b0000);
      dcache_resp = 1'b1;
      cyc("dwait_go", 5'b10011, 4'b0000);
      idle();
      cyc("dwait_b", 5'b00011, 4'b1100);
      cyc("dwait_c", 5'b11111, 4'b0000);
      cnt_chk("dwait", 4, 2, 2);

      // I-cache miss
      icache_resp = 1'b0;
      cyc("imiss", 5'b00000, 4'b0000);
      idle();
      cyc("imiss_b", 5'b11111, 4'b0000);
      cnt_chk("imiss", 5, 2, 2);

      // load-use and redirect together: redirect only
      ex_mem_read = 1'b1;
      ex_rd       = 5'd9;
      id_rs1      = 5'd9;
      id_use_rs1  = 1'b1;
      ex_redirect = 1'b1;
      cyc("both_a", 5'b10011, 4'b0000);
      idle();
      cyc("both_b", 5'b00011, 4'b1100);
      cyc("both_c", 5'b11111, 4'b0000);
      cnt_chk("both", 5, 2, 3);

      // freeze while in LU_BUBBLE: flush still fires, state held
      ex_mem_read = 1'b1;
      ex_rd       = 5'd3;
      id_rs2      = 5'd3;
      id_use_rs2  = 1'b1;
      cyc("lufz_a", 5'b00011, 4'b0000);
      idle();
      icache_resp = 1'b0;
      cyc("lufz_b", 5'b00000, 4'b0100);
      cyc("lufz_c", 5'b00000, 4'b0000);
      icache_resp = 1'b1;
      cyc("lufz_d", 5'b00011, 4'b0000);
      cyc("lufz_e", 5'b11111, 4'b0000);
      cnt_chk("lufz", 7, 3, 3);

      // reset in the middle of a redirect
      ex_redirect = 1'b1;
      cyc("rstmid_a", 5'b10011, 4'b0000);
      idle();
      rst = 1'b1;
      cyc("rstmid_b", 5'b00000, 4'b1100);
      cyc("rstmid_c", 5'b00000, 4'b1111);
      rst = 1'b0;
      cyc("rstmid_d", 5'b10000, 4'b1111);
      cyc("rstmid_e", 5'b11111, 4'b0000);
      cnt_chk("rstmid", 0, 0, 0);

      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
